// File: rtl/apple2_disk_pkg.sv
// apple2_disk_pkg: constants, writeback states and the LBA formula shared by the track loader and writeback.
package apple2_disk_pkg;
    localparam int SECTORS_PER_TRACK = 13;
    localparam int TRACK_W = 6;
    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} wb_state_t;
    function automatic logic [31:0] track_lba(input logic [31:0] trk, input logic [31:0] sectors);
        return trk * sectors;
    endfunction
endpackage

// File: rtl/sd_edge_det.sv
// sd_edge_det: sd_ack rise/fall pulses against a registered copy of sd_ack.
module sd_edge_det (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic sd_ack,
    output logic ack_rise,
    output logic ack_fall
);
    logic old_ack_q;
    always_ff @(posedge clk_sys) begin
        if (!reset_n) old_ack_q <= 1'b0;
        else old_ack_q <= sd_ack;
    end
    assign ack_rise = sd_ack & ~old_ack_q;
    assign ack_fall = ~sd_ack & old_ack_q;
endmodule

// File: rtl/track_writeback.sv
// track_writeback: writes a dirty track from track RAM back to the SD image through hps_io block writes.
module track_writeback #(
    parameter int SECTORS = apple2_disk_pkg::SECTORS_PER_TRACK,
    parameter int TRACK_W = apple2_disk_pkg::TRACK_W,
    parameter int SEC_W   = 4
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [TRACK_W-1:0] track,
    input  logic [TRACK_W-1:0] res_track,
    input  logic               dirty_set,
    input  logic               flush,
    input  logic               img_mounted,
    input  logic               img_size_nz,
    output logic [31:0]        sd_lba,
    output logic               sd_wr,
    input  logic               sd_ack,
    input  logic [8:0]         sd_buff_addr,
    output logic [7:0]         sd_buff_din,
    output logic [SEC_W+8:0]   tram_addr,
    input  logic [7:0]         tram_dout,
    output logic               load_hold,
    output logic               cpu_wait,
    output logic               busy
);
    import apple2_disk_pkg::*;
    localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(SECTORS - 1);
    wb_state_t state_q, state_d;
    logic [TRACK_W-1:0] wb_track_q, wb_track_d;
    logic [31:0] sd_lba_q, sd_lba_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic sd_wr_q, sd_wr_d;
    logic dirty_q, dirty_d;
    logic redirty_q, redirty_d;
    logic abort_q, abort_d;
    logic busy_q, busy_d;
    logic cpu_wait_q, cpu_wait_d;
    logic load_hold_q, load_hold_d;
    logic ack_rise, ack_fall;
    logic mismatch, trigger, abort, last_sec;

    sd_edge_det u_edge (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .sd_ack   (sd_ack),
        .ack_rise (ack_rise),
        .ack_fall (ack_fall)
    );

    assign mismatch = track != res_track;
    assign trigger  = dirty_q & img_size_nz & (flush | mismatch) & ~img_mounted;
    assign abort    = abort_q | img_mounted;
    assign last_sec = sec_q == LAST_SEC;

    always_comb begin
        state_d     = state_q;
        wb_track_d  = wb_track_q;
        sd_lba_d    = sd_lba_q;
        sec_d       = sec_q;
        sd_wr_d     = sd_wr_q;
        dirty_d     = dirty_q;
        redirty_d   = redirty_q;
        abort_d     = abort_q;
        busy_d      = busy_q;
        cpu_wait_d  = cpu_wait_q;
        load_hold_d = load_hold_q;
        case (state_q)
            IDLE: begin
                dirty_d = (img_mounted | ~img_size_nz) ? 1'b0 : (dirty_q | dirty_set);
                if (trigger) begin
                    state_d     = REQ;
                    wb_track_d  = res_track;
                    sd_lba_d    = track_lba(32'(res_track), 32'(SECTORS));
                    sec_d       = '0;
                    sd_wr_d     = 1'b1;
                    busy_d      = 1'b1;
                    cpu_wait_d  = 1'b1;
                    load_hold_d = 1'b1;
                end
            end
            REQ: begin
                if (abort & ~sd_ack) begin
                    sd_wr_d = 1'b0;
                    state_d = DONE;
                end else if (ack_rise) begin
                    sd_wr_d  = ~last_sec & ~abort;
                    sd_lba_d = sd_lba_q + 32'd1;
                    state_d  = XFER;
                end
            end
            XFER: begin
                if (ack_fall) begin
                    sec_d      = sec_q + 1'b1;
                    cpu_wait_d = 1'b0;
                    sd_wr_d    = sd_wr_q & ~abort;
                    state_d    = (sd_wr_q & ~abort) ? REQ : DONE;
                end
            end
            default: begin
                dirty_d     = redirty_q & (wb_track_q == res_track) & ~abort_q & ~img_mounted;
                redirty_d   = 1'b0;
                abort_d     = 1'b0;
                sd_wr_d     = 1'b0;
                busy_d      = 1'b0;
                cpu_wait_d  = 1'b0;
                load_hold_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
        // a new image mid-flush must not inherit the old track's dirty state
        if (state_q == REQ || state_q == XFER) begin
            abort_d   = abort_q | img_mounted;
            redirty_d = ~img_mounted & (redirty_q | dirty_set);
            dirty_d   = dirty_q & ~img_mounted;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wb_track_q  <= '0;
            sd_lba_q    <= '0;
            sec_q       <= '0;
            sd_wr_q     <= 1'b0;
            dirty_q     <= 1'b0;
            redirty_q   <= 1'b0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
            cpu_wait_q  <= 1'b0;
            load_hold_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_track_q  <= wb_track_d;
            sd_lba_q    <= sd_lba_d;
            sec_q       <= sec_d;
            sd_wr_q     <= sd_wr_d;
            dirty_q     <= dirty_d;
            redirty_q   <= redirty_d;
            abort_q     <= abort_d;
            busy_q      <= busy_d;
            cpu_wait_q  <= cpu_wait_d;
            load_hold_q <= load_hold_d;
        end
    end

    assign sd_lba      = sd_lba_q;
    assign sd_wr       = sd_wr_q;
    assign busy        = busy_q;
    assign cpu_wait    = cpu_wait_q;
    assign tram_addr   = {sec_q, sd_buff_addr};
    assign sd_buff_din = tram_dout;
    assign load_hold   = load_hold_q | (dirty_q & img_size_nz & mismatch);
endmodule
